// File: rtl/core_reset_ce_sequencer.sv
// ---------------------------------------------------------------------------
// core_reset_ce_sequencer
//
// Purpose: clock-enable generation and core reset sequencing for a console
// core top level. One free-running divider feeds NUM_CE power-of-two clock
// enables. The reset sources (OSD reset, config change, ioctl download) are
// merged into one stretched core reset with a guaranteed hold time, and a
// sticky record of which source caused the last reset episode.
//
// Optional build macro: CE_PAUSE_EN
//   defined   -> adds pause_i; while high the divider freezes and all ce_o
//                are forced low. Reset sequencing is unaffected.
//   undefined -> no pause_i port; the divider always runs.
//
// Ports:
//   clk_sys        in   system clock
//   reset          in   async active-high reset (typically ~pll_locked)
//   pause_i        in   (CE_PAUSE_EN only) freeze divider / clock enables
//   ce_shift_i     in   per-channel log2 divide ratio, channel k at [k*SH_W +: SH_W]
//   cfg_i          in   watched config bits; any change forces a core reset
//   user_reset_i   in   OSD reset request, level
//   download_i     in   ioctl download active, level
//   ce_o           out  registered clock-enable pulses, one per channel
//   core_reset_o   out  active-high reset to the console core (registered)
//   reset_cause_o  out  sticky cause: [0] user, [1] cfg change, [2] download
// ---------------------------------------------------------------------------

// Per-channel enable: high whenever the low s divider bits are all zero,
// with s = min(shift, DIV_W). Channels therefore share the div==0 phase.
module core_reset_ce_chan #(
  parameter int DIV_W = 3,
  parameter int SH_W  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  input  logic [SH_W-1:0]  i_shift,
  output logic             o_ce
);
  logic [31:0]      w_s;
  logic [DIV_W-1:0] w_mask;
  logic             r_ce;

  // Clamp the requested shift so a wide shift field cannot ask for more
  // divider bits than exist.
  assign w_s = (32'(i_shift) > 32'(DIV_W)) ? 32'(DIV_W) : 32'(i_shift);

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < DIV_W; b++)
      if (32'(b) < w_s) w_mask[b] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ce <= 1'b0;
    else       r_ce <= i_run && ((i_div & w_mask) == '0);
  end

  assign o_ce = r_ce;
endmodule

module core_reset_ce_sequencer #(
  parameter int NUM_CE   = 2,
  parameter int DIV_W    = 3,
  parameter int SH_W     = 2,
  parameter int CFG_W    = 5,
  parameter int RST_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset,
`ifdef CE_PAUSE_EN
  input  logic                   pause_i,
`endif
  input  logic [NUM_CE*SH_W-1:0] ce_shift_i,
  input  logic [CFG_W-1:0]       cfg_i,
  input  logic                   user_reset_i,
  input  logic                   download_i,
  output logic [NUM_CE-1:0]      ce_o,
  output logic                   core_reset_o,
  output logic [2:0]             reset_cause_o
);
  typedef enum logic [1:0] {ST_ASSERT, ST_HOLD, ST_RUN} state_t;

  logic [DIV_W-1:0]  r_div;
  logic              w_run;
  logic [CFG_W-1:0]  r_cfg_q;
  logic              w_cfg_chg;
  logic [2:0]        w_src_vec;
  logic              w_src;
  state_t            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_core_reset;
  logic [2:0]        r_cause;
  logic [NUM_CE-1:0] w_ce;

`ifdef CE_PAUSE_EN
  assign w_run = ~pause_i;
`else
  assign w_run = 1'b1;
`endif

  // Divider keeps running through core reset so the core sees enables
  // while it is held in reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)      r_div <= '0;
    else if (w_run) r_div <= r_div + DIV_W'(1);
  end

  for (genvar k = 0; k < NUM_CE; k++) begin : g_ce
    core_reset_ce_chan #(.DIV_W(DIV_W), .SH_W(SH_W)) u_chan (
      .i_clk   (clk_sys),
      .i_rst   (reset),
      .i_run   (w_run),
      .i_div   (r_div),
      .i_shift (ce_shift_i[k*SH_W +: SH_W]),
      .o_ce    (w_ce[k])
    );
  end

  assign ce_o = w_ce;

  // Config change is a one-cycle strobe. cfg_q resets to 0, so a nonzero
  // cfg_i at release only lengthens the initial reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_cfg_q <= '0;
    else       r_cfg_q <= cfg_i;
  end

  assign w_cfg_chg = (r_cfg_q != cfg_i);
  assign w_src_vec = {download_i, w_cfg_chg, user_reset_i};
  assign w_src     = |w_src_vec;

  // Reset sequencer: ASSERT while any source is active, then RST_HOLD
  // quiet cycles in HOLD before releasing the core. Any source during HOLD
  // restarts the whole sequence.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ASSERT;
      r_hold_cnt   <= '0;
      r_core_reset <= 1'b1;
      r_cause      <= '0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          r_core_reset <= 1'b1;
          r_hold_cnt   <= '0;
          r_cause      <= r_cause | w_src_vec;
          if (!w_src) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          r_cause <= r_cause | w_src_vec;
          if (w_src) begin
            r_state      <= ST_ASSERT;
            r_hold_cnt   <= '0;
            r_core_reset <= 1'b1;
          end else if (r_hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
            r_state      <= ST_RUN;
            r_hold_cnt   <= '0;
            r_core_reset <= 1'b0;
          end else begin
            r_hold_cnt   <= r_hold_cnt + HOLD_W'(1);
            r_core_reset <= 1'b1;
          end
        end
        ST_RUN: begin
          r_hold_cnt <= '0;
          if (w_src) begin
            // New episode: cause is reloaded, not accumulated.
            r_state      <= ST_ASSERT;
            r_core_reset <= 1'b1;
            r_cause      <= w_src_vec;
          end else begin
            r_core_reset <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_ASSERT;
          r_hold_cnt   <= '0;
          r_core_reset <= 1'b1;
        end
      endcase
    end
  end

  assign core_reset_o  = r_core_reset;
  assign reset_cause_o = r_cause;
endmodule
